// File: rtl/branch_predict_ctrl.sv
// Branch/jump control for a 5-stage pipeline: 2-bit BHT prediction in Decode,
// resolution/redirect/flush in Execute, BHT training and saturating statistics.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCD,
  input  logic             BranchD,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             jump_or_notE,
  output logic [1:0]       PCSelF,
  output logic             FlushD_bp,
  output logic             FlushE_bp,
  output logic             mispredictE,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       bht_q [DEPTH];
  logic [1:0]       bht_d [DEPTH];
  logic             pred_taken_e_q, pred_taken_e_d;
  logic [IDX_W-1:0] idx_e_q, idx_e_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_d;
  logic             pred_taken_d;
  logic             resolved_e;
  logic             mispred_raw;
  logic             unused_pc_bits;

  assign idx_d          = PCD[IDX_W+1:2];
  assign unused_pc_bits = ^{PCD[31:IDX_W+2], PCD[1:0]};

  // Decode reads the pre-update entry even when Execute trains the same index.
  assign pred_taken_d = BranchD & bht_q[idx_d][1];
  assign resolved_e   = BranchE | JumpE;
  assign mispred_raw  = resolved_e & (jump_or_notE != pred_taken_e_q);

  always_comb begin
    PCSelF      = 2'b00;
    FlushD_bp   = 1'b0;
    FlushE_bp   = 1'b0;
    mispredictE = 1'b0;
    if (!reset) begin
      mispredictE = mispred_raw;
      if (mispred_raw) begin
        PCSelF    = jump_or_notE ? 2'b10 : 2'b11;
        FlushD_bp = 1'b1;
        FlushE_bp = 1'b1;
      end else if (pred_taken_d && !StallD) begin
        PCSelF    = 2'b01;
        FlushD_bp = 1'b1;
      end
    end
  end

  always_comb begin
    pred_taken_e_d = pred_taken_d;
    idx_e_d        = idx_d;
    if (mispred_raw || FlushE) begin
      pred_taken_e_d = 1'b0;
      idx_e_d        = '0;
    end else if (StallD) begin
      pred_taken_e_d = 1'b0;
      idx_e_d        = idx_e_q;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (BranchE) begin
      if (jump_or_notE) begin
        if (bht_q[idx_e_q] != 2'b11) bht_d[idx_e_q] = bht_q[idx_e_q] + 2'd1;
      end else begin
        if (bht_q[idx_e_q] != 2'b00) bht_d[idx_e_q] = bht_q[idx_e_q] - 2'd1;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolved_e && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispred_raw && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
      pred_taken_e_q <= 1'b0;
      idx_e_q        <= '0;
      branch_cnt_q   <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
      pred_taken_e_q <= pred_taken_e_d;
      idx_e_q        <= idx_e_d;
      branch_cnt_q   <= branch_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl; outputs are packed as
// {PCSelF, FlushD_bp, FlushE_bp, mispredictE} and {branch_cnt, mispred_cnt}.
module tb_branch_predict_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      PCD;
  logic             BranchD, StallD, FlushE, BranchE, JumpE, jump_or_notE;
  logic [1:0]       PCSelF;
  logic             FlushD_bp, FlushE_bp, mispredictE;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  logic [4:0]       outs;
  logic [7:0]       cnts;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] O_IDLE  = 5'b00_0_0_0;
  localparam logic [4:0] O_PRED  = 5'b01_1_0_0;
  localparam logic [4:0] O_MIS_T = 5'b10_1_1_1;
  localparam logic [4:0] O_MIS_N = 5'b11_1_1_1;

  branch_predict_ctrl #(.IDX_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PCD(PCD), .BranchD(BranchD), .StallD(StallD),
    .FlushE(FlushE), .BranchE(BranchE), .JumpE(JumpE), .jump_or_notE(jump_or_notE),
    .PCSelF(PCSelF), .FlushD_bp(FlushD_bp), .FlushE_bp(FlushE_bp),
    .mispredictE(mispredictE), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  assign outs = {PCSelF, FlushD_bp, FlushE_bp, mispredictE};
  assign cnts = {branch_cnt, mispred_cnt};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCD = 32'h0; BranchD = 0; StallD = 0; FlushE = 0;
    BranchE = 0; JumpE = 0; jump_or_notE = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    PCD = 32'h40; BranchD = 1; BranchE = 1; JumpE = 1; jump_or_notE = 1;
    #3;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs: got %b exp %b", outs, O_IDLE); end
    checks++; if (cnts !== 8'h00) begin errors++; $display("FAIL reset_cnts: got %h exp %h", cnts, 8'h00); end
    tick(); tick();
    checks++; if (cnts !== 8'h00) begin errors++; $display("FAIL reset_hold_cnts: got %h exp %h", cnts, 8'h00); end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_first_branch();
    idle(); PCD = 32'h40; BranchD = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t1_decode: got %b exp %b", outs, O_IDLE); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t1_exec: got %b exp %b", outs, O_MIS_T); end
    tick();
    checks++; if (cnts !== 8'h11) begin errors++; $display("FAIL t1_cnts: got %h exp %h", cnts, 8'h11); end
  endtask

  task automatic test_train_taken();
    for (int r = 0; r < 2; r++) begin
      idle(); PCD = 32'h40; BranchD = 1; #1;
      checks++; if (outs !== O_PRED) begin errors++; $display("FAIL t2_pred%0d: got %b exp %b", r, outs, O_PRED); end
      tick();
      idle(); BranchE = 1; jump_or_notE = 1; #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t2_exec%0d: got %b exp %b", r, outs, O_IDLE); end
      tick();
    end
    checks++; if (cnts !== 8'h31) begin errors++; $display("FAIL t2_cnts: got %h exp %h", cnts, 8'h31); end
  endtask

  task automatic test_mispredict_not_taken();
    // Two not-taken outcomes walk a saturated 11 down to 10, then 01.
    for (int r = 0; r < 2; r++) begin
      idle(); PCD = 32'h40; BranchD = 1; #1;
      checks++; if (outs !== O_PRED) begin errors++; $display("FAIL t3_pred%0d: got %b exp %b", r, outs, O_PRED); end
      tick();
      idle(); BranchE = 1; jump_or_notE = 0; #1;
      checks++; if (outs !== O_MIS_N) begin errors++; $display("FAIL t3_exec%0d: got %b exp %b", r, outs, O_MIS_N); end
      tick();
    end
    checks++; if (cnts !== 8'h53) begin errors++; $display("FAIL t3_cnts: got %h exp %h", cnts, 8'h53); end
    idle(); PCD = 32'h40; BranchD = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t3_weak_nt: got %b exp %b", outs, O_IDLE); end
    tick();
    idle(); tick();
  endtask

  task automatic test_override();
    idle(); PCD = 32'h48; BranchD = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t4_d0: got %b exp %b", outs, O_IDLE); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t4_train: got %b exp %b", outs, O_MIS_T); end
    tick();
    idle(); PCD = 32'h48; BranchD = 1; #1;
    checks++; if (outs !== O_PRED) begin errors++; $display("FAIL t4_pred: got %b exp %b", outs, O_PRED); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 0; PCD = 32'h48; BranchD = 1; #1;
    checks++; if (outs !== O_MIS_N) begin errors++; $display("FAIL t4_override: got %b exp %b", outs, O_MIS_N); end
    tick();
    // predTakenE must have been cleared, so a taken outcome now mispredicts.
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t4_cleared: got %b exp %b", outs, O_MIS_T); end
    tick();
    checks++; if (cnts !== 8'h86) begin errors++; $display("FAIL t4_cnts: got %h exp %h", cnts, 8'h86); end
  endtask

  task automatic test_stall_and_jumps();
    idle(); PCD = 32'h40; BranchD = 1; StallD = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t5_stall0: got %b exp %b", outs, O_IDLE); end
    tick();
    idle(); PCD = 32'h40; BranchD = 1; StallD = 1; BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t5_bubble: got %b exp %b", outs, O_MIS_T); end
    tick();
    idle(); PCD = 32'h40; BranchD = 1; #1;
    checks++; if (outs !== O_PRED) begin errors++; $display("FAIL t5_release: got %b exp %b", outs, O_PRED); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t5_resolve: got %b exp %b", outs, O_IDLE); end
    tick();
    checks++; if (cnts !== 8'hA7) begin errors++; $display("FAIL t5_cnts: got %h exp %h", cnts, 8'hA7); end
    for (int j = 0; j < 3; j++) begin
      idle(); JumpE = 1; jump_or_notE = 1; #1;
      checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t5_jump%0d: got %b exp %b", j, outs, O_MIS_T); end
      tick();
    end
    checks++; if (cnts !== 8'hDA) begin errors++; $display("FAIL t5_jump_cnts: got %h exp %h", cnts, 8'hDA); end
  endtask

  task automatic test_flush_e();
    idle(); PCD = 32'h40; BranchD = 1; FlushE = 1; #1;
    checks++; if (outs !== O_PRED) begin errors++; $display("FAIL tf_pred: got %b exp %b", outs, O_PRED); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL tf_cleared: got %b exp %b", outs, O_MIS_T); end
    tick();
    checks++; if (cnts !== 8'hEB) begin errors++; $display("FAIL tf_cnts: got %h exp %h", cnts, 8'hEB); end
  endtask

  task automatic test_saturate_and_reset();
    for (int j = 0; j < 20; j++) begin
      idle(); JumpE = 1; jump_or_notE = 1;
      tick();
    end
    checks++; if (cnts !== 8'hFF) begin errors++; $display("FAIL t6_sat: got %h exp %h", cnts, 8'hFF); end
    idle(); JumpE = 1; jump_or_notE = 1; PCD = 32'h40; BranchD = 1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t6_rst_outs: got %b exp %b", outs, O_IDLE); end
    checks++; if (cnts !== 8'h00) begin errors++; $display("FAIL t6_rst_cnts: got %h exp %h", cnts, 8'h00); end
    tick();
    idle();
    reset = 1'b0;
    PCD = 32'h40; BranchD = 1; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t6_bht0: got %b exp %b", outs, O_IDLE); end
    PCD = 32'h48; #1;
    checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL t6_bht2: got %b exp %b", outs, O_IDLE); end
    tick();
    idle(); BranchE = 1; jump_or_notE = 1; #1;
    checks++; if (outs !== O_MIS_T) begin errors++; $display("FAIL t6_post: got %b exp %b", outs, O_MIS_T); end
    tick();
    checks++; if (cnts !== 8'h11) begin errors++; $display("FAIL t6_post_cnts: got %h exp %h", cnts, 8'h11); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_first_branch();
    test_train_taken();
    test_mispredict_not_taken();
    test_override();
    test_stall_and_jumps();
    test_flush_e();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
